// File: rtl/puf_resp_capture.sv
// ---------------------------------------------------------------------------
// puf_resp_capture
//
// Registers a WIDTH-bit PUF response bus (arbiter / ring-oscillator outputs).
// Every bit is synchronised through a SYNC_STAGES flop chain. A capture
// request waits a settle window, then samples the synchronised bus and
// presents the response with a one-cycle valid pulse and a stability flag.
//
// Optional feature macro: PUF_RESP_MAJORITY_VOTE_EN
//   defined   : NUM_SAMPLES samples are taken and each bit is majority-voted.
//               stable reports whether every bit agreed across all samples.
//   undefined : a single sample is taken (NUM_SAMPLES ignored), out is that
//               sample, and stable is 1 with every out_valid.
//
// Parameters:
//   WIDTH          response bus width (>= 1)
//   SYNC_STAGES    synchroniser depth per bit (>= 2)
//   SETTLE_CYCLES  cycles waited after capture before sampling (>= 1)
//   NUM_SAMPLES    samples per vote, odd, 1..15
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in         raw asynchronous PUF response bits
//   capture    start request, level-sampled on every clk edge
//   busy       high while a capture is in progress
//   out        captured (voted) response, held until the next out_valid
//   out_valid  one-cycle pulse, out/stable updated this cycle
//   stable     1 = every bit agreed across all samples of the last capture
// ---------------------------------------------------------------------------
module puf_resp_capture #(
  parameter int WIDTH         = 32,
  parameter int SYNC_STAGES   = 2,
  parameter int SETTLE_CYCLES = 4,
  parameter int NUM_SAMPLES   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  input  logic             capture,
  output logic             busy,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic             stable
);

  // Counter widths. The sample counter must be able to hold NUM_SAMPLES
  // itself because it is incremented on the last sample as well.
  localparam int CNT_W = $clog2(NUM_SAMPLES + 1);
  localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

`ifdef PUF_RESP_MAJORITY_VOTE_EN
  localparam int EFF_SAMPLES = NUM_SAMPLES;
`else
  localparam int EFF_SAMPLES = 1;
`endif

  localparam logic [SET_W-1:0] SETTLE_LOAD = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LAST_SAMPLE = CNT_W'(EFF_SAMPLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    DONE
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [WIDTH-1:0]   sync_chain [SYNC_STAGES];
  logic [WIDTH-1:0]   sync;
  logic [SET_W-1:0]   settle_cnt;
  logic [CNT_W-1:0]   sample_cnt;
  logic [WIDTH-1:0]   vote;
  logic               all_agree;
  logic               start;

  // A request is only honoured from IDLE; requests while busy are dropped.
  assign start = (state == IDLE) && capture;
  assign busy  = (state != IDLE);

  // Synchroniser chain, clocked every cycle regardless of the FSM so the
  // synchronised bus is always fresh when the settle window ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_chain[s] <= '0;
      end
    end else begin
      sync_chain[0] <= in;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_chain[s] <= sync_chain[s-1];
      end
    end
  end

  assign sync = sync_chain[SYNC_STAGES-1];

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state logic. DONE always returns to IDLE so a request in the
  // out_valid cycle is picked up on the following edge.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (capture) begin
          state_next = SETTLE;
        end
      end
      SETTLE: begin
        if (settle_cnt == '0) begin
          state_next = SAMPLE;
        end
      end
      SAMPLE: begin
        if (sample_cnt == LAST_SAMPLE) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Settle and sample counters. The settle counter is loaded with
  // SETTLE_CYCLES-1 so SETTLE lasts exactly SETTLE_CYCLES cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settle_cnt <= '0;
      sample_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (capture) begin
            settle_cnt <= SETTLE_LOAD;
            sample_cnt <= '0;
          end
        end
        SETTLE: begin
          if (settle_cnt != '0) begin
            settle_cnt <= settle_cnt - SET_W'(1);
          end
        end
        SAMPLE: begin
          sample_cnt <= sample_cnt + CNT_W'(1);
        end
        default: begin
        end
      endcase
    end
  end

`ifdef PUF_RESP_MAJORITY_VOTE_EN
  localparam logic [CNT_W-1:0] HALF = CNT_W'(NUM_SAMPLES / 2);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(NUM_SAMPLES);

  logic [CNT_W-1:0] ones [WIDTH];

  // Per-bit ones counters, cleared on an accepted request and accumulated
  // once per SAMPLE cycle. They cannot exceed NUM_SAMPLES.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WIDTH; i++) begin
        ones[i] <= '0;
      end
    end else if (start) begin
      for (int i = 0; i < WIDTH; i++) begin
        ones[i] <= '0;
      end
    end else if (state == SAMPLE) begin
      for (int i = 0; i < WIDTH; i++) begin
        ones[i] <= ones[i] + CNT_W'(sync[i]);
      end
    end
  end

  // Majority vote per bit; a bit is stable only when all samples agreed.
  always_comb begin
    vote      = '0;
    all_agree = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      vote[i] = (ones[i] > HALF);
      if (!((ones[i] == '0) || (ones[i] == FULL))) begin
        all_agree = 1'b0;
      end
    end
  end
`else
  logic [WIDTH-1:0] sample_reg;

  // Single-sample capture: the bus seen in the one SAMPLE cycle is kept
  // and presented unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_reg <= '0;
    end else if (state == SAMPLE) begin
      sample_reg <= sync;
    end
  end

  always_comb begin
    vote      = sample_reg;
    all_agree = 1'b1;
  end
`endif

  // Result registers, updated on the edge leaving DONE. out and stable hold
  // until the next result; out_valid is a single-cycle pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out       <= '0;
      stable    <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (state == DONE) begin
        out       <= vote;
        stable    <= all_agree;
        out_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_puf_resp_capture.sv
// ---------------------------------------------------------------------------
// tb_puf_resp_capture
//
// Self-checking bench for puf_resp_capture with default parameters. A
// behavioural reference model (sample queue, per-bit ones tallies, capture
// age counter) is compared against the DUT on every falling edge, alongside
// a table of directed vectors and hand-written multi-cycle sequences for
// reset, held capture and ignored capture requests. Works for both builds
// of PUF_RESP_MAJORITY_VOTE_EN.
// ---------------------------------------------------------------------------
module tb_puf_resp_capture;

  localparam int WIDTH         = 32;
  localparam int SYNC_STAGES   = 2;
  localparam int SETTLE_CYCLES = 4;
  localparam int NUM_SAMPLES   = 5;

`ifdef PUF_RESP_MAJORITY_VOTE_EN
  localparam int NEFF    = NUM_SAMPLES;
  localparam int EXP_LAT = 10;
`else
  localparam int NEFF    = 1;
  localparam int EXP_LAT = 6;
`endif

  // A new request is accepted one cycle after the previous result.
  localparam int PERIOD = EXP_LAT + 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [WIDTH-1:0] in = '0;
  logic             capture = 1'b0;
  logic             busy;
  logic [WIDTH-1:0] out;
  logic             out_valid;
  logic             stable;

  int check_count = 0;
  int pass_count  = 0;

  typedef struct {
    logic [WIDTH-1:0] base;
    bit               noisy;
    logic [4:0]       noise;
    logic [WIDTH-1:0] exp_out;
    bit               exp_stable;
  } vec_t;

  vec_t vecs [6];

  puf_resp_capture #(
    .WIDTH        (WIDTH),
    .SYNC_STAGES  (SYNC_STAGES),
    .SETTLE_CYCLES(SETTLE_CYCLES),
    .NUM_SAMPLES  (NUM_SAMPLES)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in       (in),
    .capture  (capture),
    .busy     (busy),
    .out      (out),
    .out_valid(out_valid),
    .stable   (stable)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [WIDTH-1:0] got,
                             input logic [WIDTH-1:0] exp);
    check_count++;
    if (got === exp) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Reference model: the bus seen by the sampler is the input from
  // SYNC_STAGES edges earlier; samples are taken SETTLE_CYCLES+1 ..
  // SETTLE_CYCLES+NEFF edges after acceptance and the result appears one
  // edge later.
  logic [WIDTH-1:0] m_sync_q [$];
  int               m_ones [WIDTH];
  bit               m_busy = 1'b0;
  int               m_age = 0;
  logic [WIDTH-1:0] m_out = '0;
  bit               m_valid = 1'b0;
  bit               m_stable = 1'b0;

  always @(posedge clk or negedge rst_n) begin : ref_model
    logic [WIDTH-1:0] sync_now;
    if (!rst_n) begin
      m_sync_q.delete();
      for (int s = 0; s < SYNC_STAGES; s++) m_sync_q.push_back('0);
      for (int i = 0; i < WIDTH; i++) m_ones[i] = 0;
      m_busy   = 1'b0;
      m_age    = 0;
      m_out    = '0;
      m_valid  = 1'b0;
      m_stable = 1'b0;
    end else begin
      sync_now = m_sync_q.pop_front();
      m_sync_q.push_back(in);
      m_valid = 1'b0;
      if (m_busy) begin
        m_age++;
        if (m_age >= SETTLE_CYCLES + 1 && m_age <= SETTLE_CYCLES + NEFF) begin
          for (int i = 0; i < WIDTH; i++) m_ones[i] += int'(sync_now[i]);
        end
        if (m_age == SETTLE_CYCLES + NEFF + 1) begin
          m_stable = 1'b1;
          for (int i = 0; i < WIDTH; i++) begin
            m_out[i] = (m_ones[i] > NEFF / 2);
            if (!(m_ones[i] == 0 || m_ones[i] == NEFF)) m_stable = 1'b0;
          end
          m_valid = 1'b1;
          m_busy  = 1'b0;
        end
      end else if (capture) begin
        m_busy = 1'b1;
        m_age  = 0;
        for (int i = 0; i < WIDTH; i++) m_ones[i] = 0;
      end
    end
  end

  // Continuous comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("model_busy", WIDTH'(busy), WIDTH'(m_busy));
      checkOutput("model_out_valid", WIDTH'(out_valid), WIDTH'(m_valid));
      checkOutput("model_out", out, m_out);
      checkOutput("model_stable", WIDTH'(stable), WIDTH'(m_stable));
    end
  end

  // One capture with an optional per-sample pattern on bit 0. Sample k is
  // taken from the input driven before edge E0+SETTLE_CYCLES+1+k-SYNC_STAGES.
  task automatic applyStimulus(input vec_t v, output int lat, output int pulses,
                               output logic [WIDTH-1:0] got_out,
                               output logic got_stable);
    lat        = -1;
    pulses     = 0;
    got_out    = '0;
    got_stable = 1'b0;
    @(negedge clk);
    in      = v.base;
    capture = 1'b1;
    @(posedge clk);
    for (int c = 0; c < EXP_LAT + 6; c++) begin
      int k;
      @(negedge clk);
      capture = 1'b0;
      if (out_valid) begin
        pulses++;
        if (lat < 0) begin
          lat        = c;
          got_out    = out;
          got_stable = stable;
        end
      end
      k = c + 1 - (SETTLE_CYCLES + 1 - SYNC_STAGES);
      if (v.noisy && k >= 0 && k < 5) in[0] = v.noise[4-k];
    end
  endtask

  initial begin
    int               lat;
    int               pulses;
    int               first;
    int               second;
    int               busy_low_held;
    int               pulses_held;
    logic [WIDTH-1:0] got_out;
    logic             got_stable;

    vecs[0] = '{32'hA5A5_5A5A, 1'b0, 5'b00000, 32'hA5A5_5A5A, 1'b1};
    vecs[1] = '{32'h0000_FFFF, 1'b0, 5'b00000, 32'h0000_FFFF, 1'b1};
`ifdef PUF_RESP_MAJORITY_VOTE_EN
    vecs[2] = '{32'h0000_0000, 1'b1, 5'b10110, 32'h0000_0001, 1'b0};
    vecs[3] = '{32'h0000_0000, 1'b1, 5'b01001, 32'h0000_0000, 1'b0};
    vecs[4] = '{32'h0000_00F0, 1'b1, 5'b11100, 32'h0000_00F1, 1'b0};
`else
    vecs[2] = '{32'h0000_0000, 1'b1, 5'b10110, 32'h0000_0001, 1'b1};
    vecs[3] = '{32'h0000_0000, 1'b1, 5'b01001, 32'h0000_0000, 1'b1};
    vecs[4] = '{32'h0000_00F0, 1'b1, 5'b11100, 32'h0000_00F1, 1'b1};
`endif
    vecs[5] = '{32'hFFFF_FFFF, 1'b0, 5'b00000, 32'hFFFF_FFFF, 1'b1};

    // Reset state.
    repeat (3) @(negedge clk);
    checkOutput("rst_busy", WIDTH'(busy), '0);
    checkOutput("rst_out", out, '0);
    checkOutput("rst_out_valid", WIDTH'(out_valid), '0);
    checkOutput("rst_stable", WIDTH'(stable), '0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Directed vectors.
    for (int n = 0; n < 6; n++) begin
      applyStimulus(vecs[n], lat, pulses, got_out, got_stable);
      checkOutput($sformatf("tbl%0d_latency", n), WIDTH'(lat), WIDTH'(EXP_LAT));
      checkOutput($sformatf("tbl%0d_pulses", n), WIDTH'(pulses), WIDTH'(1));
      checkOutput($sformatf("tbl%0d_out", n), got_out, vecs[n].exp_out);
      checkOutput($sformatf("tbl%0d_stable", n), WIDTH'(got_stable),
                  WIDTH'(vecs[n].exp_stable));
    end

    // Asynchronous reset in the middle of SETTLE.
    @(negedge clk);
    in      = 32'h1234_5678;
    capture = 1'b1;
    @(posedge clk);
    @(negedge clk);
    capture = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrst_busy", WIDTH'(busy), '0);
    checkOutput("midrst_out", out, '0);
    checkOutput("midrst_out_valid", WIDTH'(out_valid), '0);
    checkOutput("midrst_stable", WIDTH'(stable), '0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    pulses = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (out_valid) pulses++;
    end
    checkOutput("midrst_no_pulse", WIDTH'(pulses), '0);

    // Capture held high for 25 edges: back-to-back captures.
    @(negedge clk);
    capture = 1'b1;
    @(posedge clk);
    first = -1;
    second = -1;
    pulses = 0;
    busy_low_held = 0;
    pulses_held = 0;
    for (int c = 0; c < 45; c++) begin
      @(negedge clk);
      if (c == 24) capture = 1'b0;
      if (out_valid) begin
        pulses++;
        if (first < 0) first = c;
        else if (second < 0) second = c;
      end
      if (c <= 23) begin
        if (!busy) busy_low_held++;
        if (out_valid) pulses_held++;
      end
    end
    checkOutput("held_first", WIDTH'(first), WIDTH'(EXP_LAT));
    checkOutput("held_gap", WIDTH'(second - first), WIDTH'(PERIOD));
    checkOutput("held_pulses", WIDTH'(pulses), WIDTH'(24 / PERIOD + 1));
    checkOutput("held_pulses_window", WIDTH'(pulses_held),
                WIDTH'((23 - EXP_LAT) / PERIOD + 1));
    checkOutput("held_busy_low", WIDTH'(busy_low_held),
                WIDTH'((23 - EXP_LAT) / PERIOD + 1));

    // Extra requests at +3 and +7 while a capture is in flight.
    @(negedge clk);
    capture = 1'b1;
    @(posedge clk);
    first = -1;
    pulses = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      capture = (c == 2 || c == 6);
      if (out_valid) begin
        pulses++;
        if (first < 0) first = c;
      end
    end
    checkOutput("busycap_first", WIDTH'(first), WIDTH'(EXP_LAT));
    checkOutput("busycap_pulses", WIDTH'(pulses), WIDTH'((EXP_LAT <= 6) ? 2 : 1));

    // Randomised traffic checked by the reference model.
    for (int c = 0; c < 400; c++) begin
      int idx;
      @(negedge clk);
      if ($urandom_range(0, 7) == 0) in = $urandom;
      if ($urandom_range(0, 5) == 0) begin
        idx = $urandom_range(0, WIDTH - 1);
        in[idx] = ~in[idx];
      end
      capture = ($urandom_range(0, 3) == 0);
      if (c == 200) begin
        #3 rst_n = 1'b0;
        #4 rst_n = 1'b1;
      end
    end
    @(negedge clk);
    capture = 1'b0;
    repeat (15) @(negedge clk);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
